// File: rtl/snitch_fp_ss_arbiter.sv
// Round-robin arbiter sharing one FP subsystem among NrReq cores, with per-core in-flight
// limits and id-based response routing. Define SNITCH_FP_ARB_PERF_EN to enable the perf counters.
module snitch_fp_ss_arbiter #(
    parameter int unsigned NrReq          = 2,
    parameter int unsigned PayloadWidth   = 224,
    parameter int unsigned IdWidth        = 5,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned IdxW          = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NrReq-1:0][PayloadWidth-1:0]   req_payload_i,
    input  logic [NrReq-1:0][IdWidth-1:0]        req_id_i,
    input  logic [NrReq-1:0]                     req_valid_i,
    output logic [NrReq-1:0]                     req_ready_o,
    output logic [PayloadWidth-1:0]              fp_payload_o,
    output logic [IdxW+IdWidth-1:0]              fp_id_o,
    output logic                                 fp_valid_o,
    input  logic                                 fp_ready_i,
    input  logic [63:0]                          fp_resp_data_i,
    input  logic [IdxW+IdWidth-1:0]              fp_resp_id_i,
    input  logic                                 fp_resp_error_i,
    input  logic                                 fp_resp_valid_i,
    output logic                                 fp_resp_ready_o,
    output logic [63:0]                          resp_data_o,
    output logic [IdWidth-1:0]                   resp_id_o,
    output logic                                 resp_error_o,
    output logic [NrReq-1:0]                     resp_valid_o,
    input  logic [NrReq-1:0]                     resp_ready_i,
    output logic                                 busy_o,
    output logic                                 route_err_o,
    output logic [NrReq-1:0][31:0]               perf_grant_o,
    output logic [31:0]                          perf_stall_o
);

    localparam int unsigned     OutW   = $clog2(MaxOutstanding + 1);
    localparam logic [OutW-1:0] OutMax = OutW'(MaxOutstanding);

    logic [IdxW-1:0]  rr_r, sel_r, win_s, resp_idx_s;
    logic             lock_r, found_s, resp_idx_ok_s, route_err_r;
    logic [NrReq-1:0] elig_s, ready_s, req_hs_s, resp_hs_s, busy_vec_s;
    logic [OutW-1:0]  outst_r [NrReq];

    // Response decode: the upper id bits name the destination core; unknown indices are drained.
    always_comb begin
        resp_idx_s      = fp_resp_id_i[IdxW+IdWidth-1 -: IdxW];
        resp_idx_ok_s   = (32'(resp_idx_s) < NrReq);
        resp_valid_o    = {NrReq{1'b0}};
        resp_hs_s       = {NrReq{1'b0}};
        fp_resp_ready_o = 1'b1;
        for (int k = 0; k < NrReq; k++) begin
            if (resp_idx_ok_s && (resp_idx_s == IdxW'(k))) begin
                resp_valid_o[k] = fp_resp_valid_i;
                fp_resp_ready_o = resp_ready_i[k];
                resp_hs_s[k]    = fp_resp_valid_i & resp_ready_i[k];
            end else begin
                resp_hs_s[k]    = 1'b0;
            end
        end
    end

    assign resp_data_o  = fp_resp_data_i;
    assign resp_id_o    = fp_resp_id_i[IdWidth-1:0];
    assign resp_error_o = fp_resp_error_i;

    // Winner selection: a held lock wins, otherwise first eligible core at or after rr_r.
    always_comb begin
        logic [IdxW-1:0] cand;
        cand    = {IdxW{1'b0}};
        win_s   = {IdxW{1'b0}};
        found_s = 1'b0;
        for (int k = 0; k < NrReq; k++) begin
            // A response freeing a slot this cycle makes a full core eligible again.
            elig_s[k] = req_valid_i[k] & ((outst_r[k] < OutMax) | resp_hs_s[k]);
        end
        if (lock_r && elig_s[sel_r]) begin
            win_s   = sel_r;
            found_s = 1'b1;
        end else begin
            for (int i = NrReq - 1; i >= 0; i--) begin
                cand    = IdxW'((32'(rr_r) + 32'(i)) % NrReq);
                win_s   = elig_s[cand] ? cand : win_s;
                found_s = found_s | elig_s[cand];
            end
        end
        for (int k = 0; k < NrReq; k++) begin
            ready_s[k]  = found_s & (win_s == IdxW'(k)) & fp_ready_i;
            req_hs_s[k] = req_valid_i[k] & ready_s[k];
        end
    end

    assign req_ready_o  = ready_s;
    assign fp_valid_o   = found_s;
    assign fp_payload_o = req_payload_i[win_s];
    assign fp_id_o      = {win_s, req_id_i[win_s]};

    // Round-robin pointer and winner lock across downstream back-pressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_r   <= {IdxW{1'b0}};
            lock_r <= 1'b0;
            sel_r  <= {IdxW{1'b0}};
        end else if (found_s && fp_ready_i) begin
            rr_r   <= IdxW'((32'(win_s) + 32'd1) % NrReq);
            lock_r <= 1'b0;
        end else if (found_s) begin
            lock_r <= 1'b1;
            sel_r  <= win_s;
        end else begin
            lock_r <= 1'b0;
        end
    end

    // Per-core in-flight counters; saturate at both ends, simultaneous inc/dec cancels.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NrReq; k++) outst_r[k] <= {OutW{1'b0}};
        end else begin
            for (int k = 0; k < NrReq; k++) begin
                if (req_hs_s[k] && !resp_hs_s[k] && (outst_r[k] != OutMax)) begin
                    outst_r[k] <= outst_r[k] + {{(OutW-1){1'b0}}, 1'b1};
                end else if (resp_hs_s[k] && !req_hs_s[k] && (outst_r[k] != {OutW{1'b0}})) begin
                    outst_r[k] <= outst_r[k] - {{(OutW-1){1'b0}}, 1'b1};
                end else begin
                    outst_r[k] <= outst_r[k];
                end
            end
        end
    end

    // Sticky flag for responses carrying an index with no matching core.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            route_err_r <= 1'b0;
        end else if (fp_resp_valid_i && !resp_idx_ok_s) begin
            route_err_r <= 1'b1;
        end else begin
            route_err_r <= route_err_r;
        end
    end

    // Busy is derived purely from counter flops.
    always_comb begin
        for (int k = 0; k < NrReq; k++) busy_vec_s[k] = (outst_r[k] != {OutW{1'b0}});
    end

    assign busy_o      = |busy_vec_s;
    assign route_err_o = route_err_r;

`ifdef SNITCH_FP_ARB_PERF_EN
    logic [NrReq-1:0][31:0] perf_grant_r;
    logic [31:0]            perf_stall_r;

    // Wrapping grant and stall counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_grant_r <= {(NrReq*32){1'b0}};
            perf_stall_r <= 32'd0;
        end else begin
            for (int k = 0; k < NrReq; k++) begin
                perf_grant_r[k] <= perf_grant_r[k] + {31'd0, req_hs_s[k]};
            end
            perf_stall_r <= perf_stall_r + {31'd0, (found_s & ~fp_ready_i)};
        end
    end

    assign perf_grant_o = perf_grant_r;
    assign perf_stall_o = perf_stall_r;
`else
    assign perf_grant_o = {(NrReq*32){1'b0}};
    assign perf_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_snitch_fp_ss_arbiter.sv
// Self-checking bench for snitch_fp_ss_arbiter (three cores, so an out-of-range index exists).
// Expected grants are queued when stimulus is driven and popped when the fp port is sampled.
module tb_snitch_fp_ss_arbiter;

    localparam int NR  = 3;
    localparam int PW  = 224;
    localparam int IW  = 5;
    localparam int IXW = 2;

    typedef logic [IXW+IW+PW-1:0] grant_t;

    logic                     clk = 1'b0;
    logic                     rst_ni;
    logic [NR-1:0][PW-1:0]    req_payload;
    logic [NR-1:0][IW-1:0]    req_id;
    logic [NR-1:0]            req_valid, req_ready, resp_valid, resp_ready;
    logic [PW-1:0]            fp_payload;
    logic [IXW+IW-1:0]        fp_id, fp_resp_id;
    logic                     fp_valid, fp_ready;
    logic [63:0]              fp_resp_data, resp_data;
    logic                     fp_resp_error, fp_resp_valid, fp_resp_ready;
    logic [IW-1:0]            resp_id;
    logic                     resp_error, busy, route_err;
    logic [NR-1:0][31:0]      perf_grant;
    logic [31:0]              perf_stall;

    int     total = 0;
    int     bad   = 0;
    grant_t exp_q[$];
    grant_t g;

    always #5 clk = ~clk;

    snitch_fp_ss_arbiter #(.NrReq(NR), .PayloadWidth(PW), .IdWidth(IW), .MaxOutstanding(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_payload_i(req_payload), .req_id_i(req_id), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .fp_payload_o(fp_payload), .fp_id_o(fp_id), .fp_valid_o(fp_valid), .fp_ready_i(fp_ready),
        .fp_resp_data_i(fp_resp_data), .fp_resp_id_i(fp_resp_id), .fp_resp_error_i(fp_resp_error),
        .fp_resp_valid_i(fp_resp_valid), .fp_resp_ready_o(fp_resp_ready),
        .resp_data_o(resp_data), .resp_id_o(resp_id), .resp_error_o(resp_error),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .busy_o(busy), .route_err_o(route_err),
        .perf_grant_o(perf_grant), .perf_stall_o(perf_stall)
    );

    function automatic logic [PW-1:0] rnd_pl();
        logic [PW-1:0] p;
        p = {PW{1'b0}};
        for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic idle();
        req_valid     = 3'b000;
        fp_ready      = 1'b0;
        fp_resp_valid = 1'b0;
        fp_resp_id    = 7'd0;
        fp_resp_data  = 64'd0;
        fp_resp_error = 1'b0;
        resp_ready    = 3'b000;
    endtask

    task automatic drive_req(input int k);
        req_valid[k]   = 1'b1;
        req_payload[k] = rnd_pl();
        req_id[k]      = IW'($urandom);
    endtask

    task automatic expect_grant(input int w);
        exp_q.push_back({IXW'(w), req_id[w], req_payload[w]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        rst_ni = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || route_err !== 1'b0 || fp_valid !== 1'b0 || req_ready !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: busy=%b err=%b valid=%b ready=%b, want 0 0 0 000",
                     busy, route_err, fp_valid, req_ready);
        end
        drive_req(1);
        fp_ready = 1'b1;
        #1;
        total++;
        if (fp_valid !== 1'b1 || req_ready !== 3'b010 || fp_id[IXW+IW-1 -: IXW] !== 2'd1) begin
            bad++;
            $display("FAIL reset_comb: valid=%b ready=%b idx=%0d, want 1 010 1",
                     fp_valid, req_ready, fp_id[IXW+IW-1 -: IXW]);
        end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_busy: got %b want 0", busy);
        end
        idle();
        rst_ni = 1'b1;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_req(0);
            drive_req(1);
            fp_ready = 1'b1;
            expect_grant(i % 2);
            #1;
            g = exp_q.pop_front();
            total++;
            if (fp_valid !== 1'b1 || {fp_id, fp_payload} !== g) begin
                bad++;
                $display("FAIL rr_grant%0d: got v=%b id=%h want id=%h", i, fp_valid, fp_id, g[PW +: IXW+IW]);
            end
            total++;
            if (req_ready !== (3'b001 << (i % 2))) begin
                bad++;
                $display("FAIL rr_ready%0d: got %b want %b", i, req_ready, 3'b001 << (i % 2));
            end
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rr_busy: got %b want 1", busy);
        end
    endtask

    task automatic test_lock();
        do_reset();
        @(negedge clk);
        drive_req(0);
        fp_ready = 1'b1;
        expect_grant(0);
        #1;
        g = exp_q.pop_front();
        total++;
        if ({fp_id, fp_payload} !== g) begin
            bad++;
            $display("FAIL lock_pre: got id=%h want id=%h", fp_id, g[PW +: IXW+IW]);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) drive_req(0);
            if (c == 1) drive_req(1);
            fp_ready = (c >= 3);
            expect_grant((c == 4) ? 1 : 0);
            #1;
            g = exp_q.pop_front();
            total++;
            if (fp_valid !== 1'b1 || {fp_id, fp_payload} !== g) begin
                bad++;
                $display("FAIL lock_grant%0d: got v=%b id=%h want id=%h", c, fp_valid, fp_id, g[PW +: IXW+IW]);
            end
            total++;
            if (req_ready !== ((c < 3) ? 3'b000 : ((c == 3) ? 3'b001 : 3'b010))) begin
                bad++;
                $display("FAIL lock_ready%0d: got %b", c, req_ready);
            end
        end
    endtask

    task automatic test_outstanding();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_req(0);
            fp_ready = 1'b1;
            expect_grant(0);
            #1;
            g = exp_q.pop_front();
            total++;
            if ({fp_id, fp_payload} !== g) begin
                bad++;
                $display("FAIL out_fill%0d: got id=%h want id=%h", i, fp_id, g[PW +: IXW+IW]);
            end
        end
        @(negedge clk);
        drive_req(0);
        #1;
        total++;
        if (fp_valid !== 1'b0 || req_ready !== 3'b000) begin
            bad++;
            $display("FAIL out_full_skip: valid=%b ready=%b want 0 000", fp_valid, req_ready);
        end
        @(negedge clk);
        drive_req(1);
        expect_grant(1);
        #1;
        g = exp_q.pop_front();
        total++;
        if ({fp_id, fp_payload} !== g || req_ready !== 3'b010) begin
            bad++;
            $display("FAIL out_other_served: id=%h ready=%b want id=%h ready=010", fp_id, req_ready, g[PW +: IXW+IW]);
        end
        @(negedge clk);
        req_valid[1]  = 1'b0;
        fp_resp_valid = 1'b1;
        fp_resp_id    = {2'd0, 5'd3};
        resp_ready    = 3'b001;
        expect_grant(0);
        #1;
        g = exp_q.pop_front();
        total++;
        if (fp_valid !== 1'b1 || {fp_id, fp_payload} !== g) begin
            bad++;
            $display("FAIL out_free_slot: v=%b id=%h want id=%h", fp_valid, fp_id, g[PW +: IXW+IW]);
        end
        total++;
        if (req_ready !== 3'b001 || resp_valid !== 3'b001 || fp_resp_ready !== 1'b1) begin
            bad++;
            $display("FAIL out_free_hs: ready=%b rv=%b frr=%b want 001 001 1", req_ready, resp_valid, fp_resp_ready);
        end
        @(negedge clk);
        fp_resp_valid = 1'b0;
        resp_ready    = 3'b000;
        #1;
        total++;
        if (fp_valid !== 1'b0) begin
            bad++;
            $display("FAIL out_still_full: valid=%b want 0", fp_valid);
        end
        idle();
    endtask

    task automatic test_resp_route();
        logic [63:0] d;
        do_reset();
        @(negedge clk);
        drive_req(1);
        fp_ready = 1'b1;
        expect_grant(1);
        #1;
        g = exp_q.pop_front();
        total++;
        if ({fp_id, fp_payload} !== g) begin
            bad++;
            $display("FAIL route_req: got id=%h want id=%h", fp_id, g[PW +: IXW+IW]);
        end
        @(negedge clk);
        idle();
        d             = {$urandom, $urandom};
        fp_resp_valid = 1'b1;
        fp_resp_id    = {2'd1, 5'd7};
        fp_resp_data  = d;
        fp_resp_error = 1'b1;
        #1;
        total++;
        if (resp_valid !== 3'b010 || fp_resp_ready !== 1'b0) begin
            bad++;
            $display("FAIL route_stall: rv=%b frr=%b want 010 0", resp_valid, fp_resp_ready);
        end
        total++;
        if (resp_data !== d || resp_id !== 5'd7 || resp_error !== 1'b1) begin
            bad++;
            $display("FAIL route_bcast: data=%h id=%0d err=%b want %h 7 1", resp_data, resp_id, resp_error, d);
        end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL route_busy_held: got %b want 1", busy);
        end
        resp_ready = 3'b010;
        #1;
        total++;
        if (fp_resp_ready !== 1'b1) begin
            bad++;
            $display("FAIL route_ready: got %b want 1", fp_resp_ready);
        end
        @(negedge clk);
        fp_resp_id = {2'd0, 5'd1};
        resp_ready = 3'b001;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL route_dec: busy=%b want 0", busy);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL route_saturate: busy=%b want 0", busy);
        end
    endtask

    task automatic test_route_err();
        do_reset();
        @(negedge clk);
        fp_resp_valid = 1'b1;
        fp_resp_id    = {2'd3, 5'd2};
        resp_ready    = 3'b111;
        #1;
        total++;
        if (fp_resp_ready !== 1'b1 || resp_valid !== 3'b000) begin
            bad++;
            $display("FAIL err_drain: frr=%b rv=%b want 1 000", fp_resp_ready, resp_valid);
        end
        @(negedge clk);
        idle();
        drive_req(2);
        fp_ready = 1'b1;
        expect_grant(2);
        #1;
        g = exp_q.pop_front();
        total++;
        if ({fp_id, fp_payload} !== g || route_err !== 1'b1) begin
            bad++;
            $display("FAIL err_set: id=%h err=%b want id=%h err=1", fp_id, route_err, g[PW +: IXW+IW]);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (route_err !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: err=%b busy=%b want 1 1", route_err, busy);
        end
        rst_ni = 1'b0;
        #1;
        total++;
        if (route_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL err_midreset: err=%b busy=%b want 0 0", route_err, busy);
        end
        #1;
        rst_ni = 1'b1;
        total++;
        if (perf_grant !== {(NR*32){1'b0}} || perf_stall !== 32'd0) begin
            bad++;
            $display("FAIL perf_tied: grant=%h stall=%h want 0", perf_grant, perf_stall);
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_payload = {(NR*PW){1'b0}};
        req_id      = {(NR*IW){1'b0}};
        idle();
        test_reset();
        test_round_robin();
        test_lock();
        test_outstanding();
        test_resp_route();
        test_route_err();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
